// File: rtl/reg_unlock_pkg.sv
// Shared types and default keys for the two-key register unlock controller.
package reg_unlock_pkg;

  typedef enum logic [1:0] {
    StLocked   = 2'd0,
    StKey1Wait = 2'd1,
    StUnlocked = 2'd2,
    StLockout  = 2'd3
  } unlock_state_e;

  localparam logic [15:0] DefaultKey0 = 16'hA5A5;
  localparam logic [15:0] DefaultKey1 = 16'h5A5A;

endpackage

// File: rtl/reg_unlock_ctrl.sv
// Two-key unlock sequencer guarding a single write to a downstream locked register,
// with a time window per step and a permanent lockout after repeated failures.
module reg_unlock_ctrl
  import reg_unlock_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] KEY0     = WIDTH'(DefaultKey0),
  parameter logic [WIDTH-1:0] KEY1     = WIDTH'(DefaultKey1),
  parameter int unsigned      WINDOW   = 16,
  parameter int unsigned      MAX_FAIL = 3,
  localparam int unsigned     FailW    = $clog2(MAX_FAIL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [WIDTH-1:0] key_data,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             lock_req,
  output logic             write_en,
  output logic [WIDTH-1:0] data_in,
  output logic             unlocked,
  output logic             lockout,
  output logic             wr_denied,
  output logic [FailW-1:0] fail_cnt
);

  localparam int unsigned       TimerW    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(WINDOW - 1);
  localparam logic [TimerW-1:0] TimerOne  = TimerW'(1);
  localparam logic [FailW-1:0]  FailMax   = FailW'(MAX_FAIL);
  localparam logic [FailW-1:0]  FailOne   = FailW'(1);

  unlock_state_e     state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [FailW-1:0]  fail_cnt_q, fail_cnt_d;
  logic              write_en_q, write_en_d;
  logic [WIDTH-1:0]  data_in_q, data_in_d;
  logic              wr_denied_q, wr_denied_d;
  logic              unlocked_q, lockout_q;
  logic              fail_event;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    fail_cnt_d  = fail_cnt_q;
    write_en_d  = 1'b0;
    data_in_d   = data_in_q;
    wr_denied_d = 1'b0;
    fail_event  = 1'b0;

    unique case (state_q)
      StLocked: begin
        wr_denied_d = wr_req;
        if (!lock_req && key_valid) begin
          if (key_data == KEY0) begin
            state_d = StKey1Wait;
            timer_d = TimerLoad;
          end else begin
            fail_event = 1'b1;
          end
        end
      end
      StKey1Wait: begin
        wr_denied_d = wr_req;
        if (lock_req) begin
          state_d = StLocked;
        end else if (key_valid && key_data == KEY1) begin
          state_d    = StUnlocked;
          fail_cnt_d = '0;
          timer_d    = TimerLoad;
        end else if (key_valid || timer_q == '0) begin
          fail_event = 1'b1;
        end else begin
          timer_d = timer_q - TimerOne;
        end
      end
      StUnlocked: begin
        // Keys are ignored here; relock beats a same-cycle write.
        if (lock_req) begin
          state_d     = StLocked;
          wr_denied_d = wr_req;
        end else if (wr_req) begin
          state_d    = StLocked;
          write_en_d = 1'b1;
          data_in_d  = wr_data;
        end else if (timer_q == '0) begin
          state_d = StLocked;
        end else begin
          timer_d = timer_q - TimerOne;
        end
      end
      StLockout: begin
        wr_denied_d = wr_req;
      end
      default: state_d = StLocked;
    endcase

    if (fail_event) begin
      if (fail_cnt_q != FailMax) begin
        fail_cnt_d = fail_cnt_q + FailOne;
      end
      state_d = (fail_cnt_d == FailMax) ? StLockout : StLocked;
    end

    // Timer only runs while a window is open; park it at zero otherwise.
    if (state_d != StKey1Wait && state_d != StUnlocked) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StLocked;
      timer_q     <= '0;
      fail_cnt_q  <= '0;
      write_en_q  <= 1'b0;
      data_in_q   <= '0;
      wr_denied_q <= 1'b0;
      unlocked_q  <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      fail_cnt_q  <= fail_cnt_d;
      write_en_q  <= write_en_d;
      data_in_q   <= data_in_d;
      wr_denied_q <= wr_denied_d;
      unlocked_q  <= (state_d == StUnlocked);
      lockout_q   <= (state_d == StLockout);
    end
  end

  assign write_en  = write_en_q;
  assign data_in   = data_in_q;
  assign unlocked  = unlocked_q;
  assign lockout   = lockout_q;
  assign wr_denied = wr_denied_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_reg_unlock_ctrl.sv
// Self-checking bench for reg_unlock_ctrl: directed vector table, corner sequences and
// random traffic against a deadline-based behavioural model.
module tb_reg_unlock_ctrl;

  localparam logic [15:0] K0  = 16'hA5A5;
  localparam logic [15:0] K1  = 16'h5A5A;
  localparam int          WIN = 16;
  localparam int          MAXF = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [15:0] key_data = '0;
  logic        wr_req = 1'b0;
  logic [15:0] wr_data = '0;
  logic        lock_req = 1'b0;
  logic        write_en;
  logic [15:0] data_in;
  logic        unlocked;
  logic        lockout;
  logic        wr_denied;
  logic [1:0]  fail_cnt;

  reg_unlock_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_data  (key_data),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .lock_req  (lock_req),
    .write_en  (write_en),
    .data_in   (data_in),
    .unlocked  (unlocked),
    .lockout   (lockout),
    .wr_denied (wr_denied),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model: mode 0 idle, 1 awaiting KEY1, 2 open for a write, 3 locked out.
  // Windows are absolute cycle deadlines rather than a countdown.
  int          m_mode, m_fails, m_deadline, m_cyc;
  logic        m_we, m_den;
  logic [15:0] m_data;

  function automatic logic [21:0] dut_outs();
    return {write_en, data_in, unlocked, lockout, wr_denied, fail_cnt};
  endfunction

  function automatic logic [21:0] model_outs();
    return {m_we, m_data, m_mode == 2, m_mode == 3, m_den, 2'(m_fails)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_mode = 0; m_fails = 0; m_deadline = 0; m_cyc = 0;
    m_we = 1'b0; m_den = 1'b0; m_data = '0;
  endfunction

  function automatic void model_fail();
    if (m_fails < MAXF) m_fails++;
    m_mode = (m_fails == MAXF) ? 3 : 0;
  endfunction

  function automatic void model_step(input logic kv, input logic [15:0] key, input logic wr,
                                     input logic [15:0] wd, input logic lk);
    m_we  = 1'b0;
    m_den = 1'b0;
    case (m_mode)
      0: begin
        m_den = wr;
        if (!lk && kv) begin
          if (key == K0) begin m_mode = 1; m_deadline = m_cyc + WIN; end
          else model_fail();
        end
      end
      1: begin
        m_den = wr;
        if (lk) m_mode = 0;
        else if (kv && key == K1) begin m_mode = 2; m_fails = 0; m_deadline = m_cyc + WIN; end
        else if (kv || m_cyc == m_deadline) model_fail();
      end
      2: begin
        if (lk) begin m_mode = 0; m_den = wr; end
        else if (wr) begin m_mode = 0; m_we = 1'b1; m_data = wd; end
        else if (m_cyc == m_deadline) m_mode = 0;
      end
      default: m_den = wr;
    endcase
    m_cyc++;
  endfunction

  // Drive one cycle of inputs from posedge+1, advance the model, land at next posedge+1.
  task automatic drive(input logic kv, input logic [15:0] key, input logic wr,
                       input logic [15:0] wd, input logic lk);
    key_valid = kv; key_data = key; wr_req = wr; wr_data = wd; lock_req = lk;
    model_step(kv, key, wr, wd, lk);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name, input logic kv, input logic [15:0] key,
                      input logic wr, input logic [15:0] wd, input logic lk);
    drive(kv, key, wr, wd, lk);
    check(name, 32'(dut_outs()), 32'(model_outs()));
  endtask

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++) step(name, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    key_valid = 1'b0; wr_req = 1'b0; lock_req = 1'b0;
    rst = 1'b1;
    #2;
    check("reset_async", 32'(dut_outs()), 32'd0);
    @(posedge clk);
    #1;
    check("reset_held", 32'(dut_outs()), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        kv;
    logic [15:0] key;
    logic        wr;
    logic [15:0] wd;
    logic        lk;
    logic [21:0] exp;  // {write_en, data_in, unlocked, lockout, wr_denied, fail_cnt}
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic saw_we;
    logic kv, wr, lk;
    logic [15:0] key;
    int r;

    // Unlock + write, denied write, then lockout by three bad keys.
    tbl[0]  = '{1'b1, K0,       1'b0, 16'h0000, 1'b0, {1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0}};
    tbl[1]  = '{1'b1, K1,       1'b0, 16'h0000, 1'b0, {1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0}};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, {1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 2'd0}};
    tbl[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, {1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 2'd0}};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, {1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, 2'd0}};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, {1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 2'd0}};
    tbl[6]  = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, {1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 2'd1}};
    tbl[7]  = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, {1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 2'd2}};
    tbl[8]  = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, {1'b0, 16'h1234, 1'b0, 1'b1, 1'b0, 2'd3}};
    tbl[9]  = '{1'b1, K0,       1'b0, 16'h0000, 1'b0, {1'b0, 16'h1234, 1'b0, 1'b1, 1'b0, 2'd3}};
    tbl[10] = '{1'b1, K1,       1'b0, 16'h0000, 1'b0, {1'b0, 16'h1234, 1'b0, 1'b1, 1'b0, 2'd3}};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 16'h1111, 1'b0, {1'b0, 16'h1234, 1'b0, 1'b1, 1'b1, 2'd3}};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, {1'b0, 16'h1234, 1'b0, 1'b1, 1'b0, 2'd3}};
    tbl[13] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, {1'b0, 16'h1234, 1'b0, 1'b1, 1'b0, 2'd3}};

    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].kv, tbl[i].key, tbl[i].wr, tbl[i].wd, tbl[i].lk);
      check($sformatf("vec%0d", i), 32'(dut_outs()), 32'(tbl[i].exp));
    end
    do_reset();

    // KEY1 window: expiry after 16 idle cycles counts one failure.
    step("t_key0", 1'b1, K0, 1'b0, '0, 1'b0);
    idle("t_wait", 15);
    check("t_pre_expiry_fail", 32'(fail_cnt), 32'd0);
    idle("t_expire", 1);
    check("t_expired_fail", 32'(fail_cnt), 32'd1);
    check("t_expired_unl", 32'(unlocked), 32'd0);

    // KEY1 on cycle 15 after KEY0 unlocks and clears the failure count.
    step("w15_key0", 1'b1, K0, 1'b0, '0, 1'b0);
    idle("w15_wait", 14);
    step("w15_key1", 1'b1, K1, 1'b0, '0, 1'b0);
    check("w15_unlocked", 32'(unlocked), 32'd1);
    check("w15_fail_clr", 32'(fail_cnt), 32'd0);
    idle("u_wait", 15);
    check("u_still_open", 32'(unlocked), 32'd1);
    idle("u_expire", 1);
    check("u_expired", 32'(unlocked), 32'd0);
    check("u_no_fail", 32'(fail_cnt), 32'd0);

    // KEY1 on the last cycle of the window still unlocks.
    step("w16_key0", 1'b1, K0, 1'b0, '0, 1'b0);
    idle("w16_wait", 15);
    step("w16_key1", 1'b1, K1, 1'b0, '0, 1'b0);
    check("w16_unlocked", 32'(unlocked), 32'd1);

    // Relock and write in the same cycle: write dropped, denial pulsed.
    step("rl_both", 1'b0, '0, 1'b1, 16'hDEAD, 1'b1);
    check("rl_we", 32'(write_en), 32'd0);
    check("rl_den", 32'(wr_denied), 32'd1);
    check("rl_unl", 32'(unlocked), 32'd0);
    idle("rl_after", 2);

    // Reset during a pending write: write_en must never rise.
    step("rw_key0", 1'b1, K0, 1'b0, '0, 1'b0);
    step("rw_key1", 1'b1, K1, 1'b0, '0, 1'b0);
    key_valid = 1'b0; wr_req = 1'b1; wr_data = 16'hCAFE; lock_req = 1'b0;
    #3;
    rst = 1'b1;
    saw_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (write_en) saw_we = 1'b1;
    end
    check("rw_outs_zero", 32'(dut_outs()), 32'd0);
    wr_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step("rw_post", 1'b0, '0, 1'b0, '0, 1'b0);
      if (write_en) saw_we = 1'b1;
    end
    check("rw_no_write", 32'(saw_we), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ((m_mode == 3 && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        kv = ($urandom_range(0, 1) == 1);
        r  = $urandom_range(0, 9);
        key = (r < 4) ? K0 : (r < 8) ? K1 : 16'($urandom);
        wr = ($urandom_range(0, 5) == 0);
        lk = ($urandom_range(0, 19) == 0);
        step("rand", kv, key, wr, 16'($urandom), lk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
